// File: rtl/fifo8x16_if.sv
// Producer/consumer handshake bundle for the eight-entry, 16-bit FIFO.
// The FIFO uses the slave modport. The environment that drives it uses master.
interface fifo8x16_if;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  count;
   logic        full;
   logic        empty;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, count, full, empty
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, count, full, empty
   );
endinterface

// File: rtl/fifo8x16.sv
// Eight-entry, 16-bit show-ahead FIFO. The head word is the 8-way mux of the
// storage registers, selected by the read pointer.
module fifo8x16 (
   input logic       clk,
   input logic       reset,
   fifo8x16_if.slave bus
);
   logic [15:0] mem_q [8];
   logic [2:0]  wr_ptr_q, rd_ptr_q;
   logic [3:0]  count_q, count_d;
   logic [7:0]  wr_en;
   logic        full, empty, push, pop;
   logic [15:0] head;

   // Status comes from registered count only, so there is no path from valid/ready.
   assign full  = (count_q == 4'd8);
   assign empty = (count_q == 4'd0);
   assign push  = bus.in_valid & ~full;
   assign pop   = bus.out_ready & ~empty;

   always_comb begin
      wr_en = 8'h00;
      if (push) begin
         wr_en[wr_ptr_q] = 1'b1;
      end
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 4'd1;
      end else if (pop && !push) begin
         count_d = count_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            mem_q[i] <= 16'h0000;
         end
         wr_ptr_q <= 3'd0;
         rd_ptr_q <= 3'd0;
         count_q  <= 4'd0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (wr_en[i]) begin
               mem_q[i] <= bus.in_data;
            end
         end
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 3'd1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 3'd1;
         end
         count_q <= count_d;
      end
   end

   always_comb begin
      case (rd_ptr_q)
         3'd0: head = mem_q[0];
         3'd1: head = mem_q[1];
         3'd2: head = mem_q[2];
         3'd3: head = mem_q[3];
         3'd4: head = mem_q[4];
         3'd5: head = mem_q[5];
         3'd6: head = mem_q[6];
         default: head = mem_q[7];
      endcase
   end

   assign bus.out_data  = head;
   assign bus.out_valid = ~empty;
   assign bus.in_ready  = ~full;
   assign bus.count     = count_q;
   assign bus.full      = full;
   assign bus.empty     = empty;
endmodule

// File: tb/tb_fifo8x16.sv
// Self-checking bench for fifo8x16, checked against a queue model of FIFO occupancy and order.
module tb_fifo8x16;
   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   logic [15:0] q[$];

   fifo8x16_if bus ();

   fifo8x16 dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Drive one cycle, advance the model on the edge, then settle 1 time unit after the edge.
   task automatic step(input logic rst, input logic iv, input logic [15:0] id, input logic ordy);
      int pre;
      @(negedge clk);
      reset         = rst;
      bus.in_valid  = iv;
      bus.in_data   = id;
      bus.out_ready = ordy;
      @(posedge clk);
      pre = q.size();
      if (rst) begin
         q.delete();
      end else begin
         if (ordy && pre > 0) void'(q.pop_front());
         if (iv && pre < 8) q.push_back(id);
      end
      #1;
   endtask

   task automatic test_reset();
      step(1'b1, 1'b1, 16'h5555, 1'b1);
      checks++;
      if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 ||
          bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: count=%0d empty=%b full=%b in_ready=%b out_valid=%b",
                  bus.count, bus.empty, bus.full, bus.in_ready, bus.out_valid);
      end
      checks++;
      if (bus.out_data !== 16'h0000) begin
         errors++;
         $display("FAIL reset_data: got %h want 0000", bus.out_data);
      end
   endtask

   logic [15:0] fill_vals [8] = '{16'hAAAA, 16'h0000, 16'h1111, 16'h4444,
                                  16'hCCCC, 16'hFFFF, 16'hDDDD, 16'hEEEE};

   task automatic test_fill();
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, fill_vals[i], 1'b0);
         checks++;
         if (bus.count !== 4'(i + 1) || bus.out_data !== 16'hAAAA) begin
            errors++;
            $display("FAIL fill_%0d: count=%0d data=%h want count=%0d data=AAAA",
                     i, bus.count, bus.out_data, i + 1);
         end
      end
      checks++;
      if (bus.full !== 1'b1 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL fill_full: full=%b in_ready=%b want 1/0", bus.full, bus.in_ready);
      end
   endtask

   task automatic test_drain();
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== fill_vals[i]) begin
            errors++;
            $display("FAIL drain_%0d: valid=%b data=%h want 1/%h",
                     i, bus.out_valid, bus.out_data, fill_vals[i]);
         end
         step(1'b0, 1'b0, 16'h0000, 1'b1);
      end
      checks++;
      if (bus.empty !== 1'b1 || bus.out_valid !== 1'b0 || bus.count !== 4'd0) begin
         errors++;
         $display("FAIL drain_empty: empty=%b valid=%b count=%0d want 1/0/0",
                  bus.empty, bus.out_valid, bus.count);
      end
   endtask

   // Pops every queued word, checking each against the model head before it leaves.
   task automatic drain_all(input string tag);
      int n;
      n = q.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (bus.out_data !== q[0]) begin
            errors++;
            $display("FAIL %s_pop%0d: got %h want %h", tag, i, bus.out_data, q[0]);
         end
         step(1'b0, 1'b0, 16'h0000, 1'b1);
      end
      checks++;
      if (bus.count !== 4'd0) begin
         errors++;
         $display("FAIL %s_end: count=%0d want 0", tag, bus.count);
      end
   endtask

   task automatic test_wrap();
      logic [15:0] w [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'($urandom), 1'b0);
      drain_all("wrap_pre");
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, w[i], 1'b0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bus.out_data !== w[i]) begin
            errors++;
            $display("FAIL wrap_%0d: got %h want %h", i, bus.out_data, w[i]);
         end
         step(1'b0, 1'b0, 16'h0000, 1'b1);
      end
   endtask

   task automatic test_full_simul();
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'($urandom) | 16'h0001, 1'b0);
      step(1'b0, 1'b1, 16'hBEEF, 1'b1);
      checks++;
      if (bus.count !== 4'd7 || bus.out_data !== q[0]) begin
         errors++;
         $display("FAIL full_simul: count=%0d data=%h want 7/%h", bus.count, bus.out_data, q[0]);
      end
      drain_all("full_simul");
   endtask

   task automatic test_empty_simul();
      step(1'b0, 1'b1, 16'h0F0F, 1'b1);
      checks++;
      if (bus.count !== 4'd1 || bus.out_data !== 16'h0F0F) begin
         errors++;
         $display("FAIL empty_simul: count=%0d data=%h want 1/0F0F", bus.count, bus.out_data);
      end
      drain_all("empty_simul");
   endtask

   task automatic test_steady();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'($urandom), 1'b0);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (bus.out_data !== q[0]) begin
            errors++;
            $display("FAIL steady_data%0d: got %h want %h", i, bus.out_data, q[0]);
         end
         step(1'b0, 1'b1, 16'($urandom), 1'b1);
         checks++;
         if (bus.count !== 4'd3) begin
            errors++;
            $display("FAIL steady_count%0d: got %0d want 3", i, bus.count);
         end
      end
      drain_all("steady");
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'($urandom) | 16'h0100, 1'b0);
      step(1'b1, 1'b1, 16'h7777, 1'b0);
      checks++;
      if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.out_data !== 16'h0000) begin
         errors++;
         $display("FAIL reset_mid: count=%0d empty=%b data=%h want 0/1/0000",
                  bus.count, bus.empty, bus.out_data);
      end
      step(1'b0, 1'b1, 16'h2222, 1'b0);
      checks++;
      if (bus.count !== 4'd1 || bus.out_valid !== 1'b1 || bus.out_data !== 16'h2222) begin
         errors++;
         $display("FAIL reset_mid_push: count=%0d valid=%b data=%h want 1/1/2222",
                  bus.count, bus.out_valid, bus.out_data);
      end
      drain_all("reset_mid");
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
         checks++;
         if (bus.count !== 4'(q.size()) || bus.full !== (q.size() == 8) ||
             bus.empty !== (q.size() == 0) || bus.in_ready !== (q.size() != 8) ||
             bus.out_valid !== (q.size() != 0)) begin
            errors++;
            $display("FAIL random_status%0d: count=%0d full=%b empty=%b want count=%0d",
                     i, bus.count, bus.full, bus.empty, q.size());
         end
         if (q.size() != 0) begin
            checks++;
            if (bus.out_data !== q[0]) begin
               errors++;
               $display("FAIL random_data%0d: got %h want %h", i, bus.out_data, q[0]);
            end
         end
      end
      drain_all("random");
   endtask

   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = 16'h0000;
      bus.out_ready = 1'b0;
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_full_simul();
      test_empty_simul();
      test_steady();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fifo8x16.md
# fifo8x16

Eight-entry, 16-bit synchronous FIFO whose storage is eight 16-bit registers and whose read path is the existing `Mux8Way16`, driven by the FIFO read pointer as `sel`. It sits directly upstream of `Mux8Way16`: it owns the eight words and the 3-bit selector the mux consumes, and it turns the mux into a show-ahead queue output. Producer and consumer attach through valid/ready handshakes.

## Interface
- (no parameters): depth 8 and width 16 are fixed by the `Mux8Way16` read path.
- `clk` input, 1: single clock; all state updates on the rising edge.
- `reset` input, 1: synchronous, active-high.
- `in_data` input, 16: write word.
- `in_valid` input, 1: producer offers `in_data`.
- `in_ready` output, 1: FIFO can accept; equals `!full`.
- `out_data` output, 16: head word; `Mux8Way16` output with `sel = rd_ptr`.
- `out_valid` output, 1: head word valid; equals `!empty`.
- `out_ready` input, 1: consumer takes the head word.
- `count` output, 4: occupancy, 0..8.
- `full` output, 1: `count == 8`.
- `empty` output, 1: `count == 0`.

## Operation
- State: `mem[0..7]` (16-bit each), `wr_ptr[2:0]`, `rd_ptr[2:0]`, `count[3:0]`.
- Push = `in_valid & in_ready`: `mem[wr_ptr] <= in_data`, `wr_ptr <= wr_ptr + 1`.
- Pop = `out_valid & out_ready`: `rd_ptr <= rd_ptr + 1`.
- Pointers are 3-bit and wrap 7 -> 0 by natural overflow. No other wrap logic.
- `count`: push only +1, pop only -1, both or neither unchanged.
- The write decode is a one-hot enable over the 8 registers (DMux8Way style). Only the `wr_ptr` register loads on a push.
- Read: `out_data` is the combinational output of `Mux8Way16(mem[0..7], rd_ptr)`. Show-ahead: the head word is present whenever `out_valid=1`, with no read-request cycle.
- `out_data` while `empty` is don't-care for consumers. It must still be the mux output of `mem[rd_ptr]` and is never forced.
- Boundaries:
  - Full: `in_ready=0`. `in_valid` is ignored and there is no overwrite. A simultaneous pop still proceeds, and `count` drops to 7.
  - Full with push and pop in the same cycle: no write-through. The push is refused and must be re-offered next cycle, when `in_ready=1`.
  - Empty: `out_valid=0`. `out_ready` is ignored, with no pointer move and no underflow. A push proceeds.
  - Empty with push and pop in the same cycle: only the push takes effect, and `count` becomes 1.
  - Neither full nor empty with push and pop: both take effect and `count` holds.
- Reset, including mid-operation: on the next rising edge with `reset=1`:
  - `wr_ptr=0`, `rd_ptr=0`, `count=0`, all `mem` words = 16'h0000.
  - Any push or pop in that cycle is discarded.
  - Outputs then read `in_ready=1`, `out_valid=0`, `empty=1`, `full=0`, `count=0`, `out_data=16'h0000`.

## Timing
- All registers update only on `posedge clk`. `reset` has priority over push and pop.
- `in_ready`, `out_valid`, `full`, `empty` and `count` decode from registered `count` only, with no combinational path from `in_valid` or `out_ready`.
- Write-to-read latency: a word pushed at edge N appears on `out_data` with `out_valid=1` after edge N, provided the FIFO was empty or that word reached the head.
- Pop: `out_data` advances to the next word after the popping edge, through a combinational mux path from `rd_ptr`.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- Reset, then fill: push 16'hAAAA, 0000, 1111, 4444, CCCC, FFFF, DDDD, EEEE on 8 consecutive cycles with `out_ready=0`.
  - Required: `count` steps 1..8, then `full=1` and `in_ready=0`.
  - Required: `out_data=16'hAAAA` throughout.
- Drain from full with `out_ready=1`: `out_data` reads AAAA, 0000, 1111, 4444, CCCC, FFFF, DDDD, EEEE on successive cycles. Then `empty=1`, `out_valid=0` and `count=0`.
- Wrap-around:
  - Push 5, pop 5, then push 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0 so that `wr_ptr` wraps 7 -> 0.
  - Required: pops return the same four words in order, with `rd_ptr` wrapping correctly.
- Simultaneous events:
  - Full plus push of 16'hBEEF plus pop: head leaves, BEEF is not stored, `count=7`.
  - Empty plus push of 16'h0F0F plus pop: `count=1` and `out_data=16'h0F0F`.
- Steady state at `count=3` with push and pop every cycle for 16 cycles: `count` stays 3 and the output order equals the input order.
- Reset mid-operation: assert `reset` for one cycle at `count=5` while pushing 16'h7777.
  - Required: `count=0`, `empty=1`, `out_data=16'h0000`.
  - Required: the next push of 16'h2222 appears as the head one cycle later.
